// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - Loader-to-CPU write port: word, byte address, strobe and load-over flag
interface uart_loader_if;
   logic [31:0] UartData;
   logic [31:0] UartAddress;
   logic        UartWrite;
   logic        UartOver;

   modport master (
      output UartData,
      output UartAddress,
      output UartWrite,
      output UartOver
   );

   modport slave (
      input UartData,
      input UartAddress,
      input UartWrite,
      input UartOver
   );
endinterface

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - 8N1 UART receiver that assembles little-endian words and writes them
// through the Uart* port while holding the CPU in reset until the load completes.
module uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int unsigned MAX_WORDS    = 16384,
   parameter int unsigned TIMEOUT_CLKS = 2_500_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx,
   input  logic                start,
   input  logic                skip_load,
   uart_loader_if.master       uart,
   output logic [15:0]         words_loaded,
   output logic [2:0]          status
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [31:0]      MAX_W     = 32'(MAX_WORDS);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;

   // ---------------- receiver ----------------
   logic             rx_meta, rx_sync;
   rx_state_t        rx_state_q, rx_state_n;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_n;
   logic [2:0]       rx_bit_q, rx_bit_n;
   logic [7:0]       rx_shift_q, rx_shift_n;
   logic             rx_done, rx_ferr;
   logic             rx_discard_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_n;
         rx_cnt_q   <= rx_cnt_n;
         rx_bit_q   <= rx_bit_n;
         rx_shift_q <= rx_shift_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state_q;
      rx_cnt_n   = rx_cnt_q + CNT_W'(1);
      rx_bit_n   = rx_bit_q;
      rx_shift_n = rx_shift_q;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (!rx_sync) rx_state_n = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = '0;
               rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_sync, rx_shift_q[7:1]};
               rx_bit_n   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               rx_done    = rx_sync;
               rx_ferr    = !rx_sync;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // A byte already on the wire when start arrives is received to completion, then thrown away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rx_discard_q <= 1'b0;
      else if (start)
         rx_discard_q <= (rx_state_n != RX_IDLE);
      else
         rx_discard_q <= rx_discard_q && (rx_state_n != RX_IDLE);
   end

   // ---------------- loader ----------------
   ld_state_t        ld_state_q, ld_state_n;
   logic [1:0]       b_q, b_n;
   logic [23:0]      buf_q, buf_n;
   logic [31:0]      n_words_q, n_words_n;
   logic [31:0]      wcnt_q, wcnt_n;
   logic [TMO_W-1:0] tmo_q, tmo_n;
   logic [1:0]       over_cnt_q, over_cnt_n;
   logic [2:0]       status_q, status_n;
   logic [31:0]      data_q, data_n;
   logic [31:0]      addr_q, addr_n;
   logic             write_q, write_n;
   logic             over_q, over_n;
   logic             byte_ok, frame_hit;
   logic [31:0]      word_asm;

   assign byte_ok   = rx_done && !rx_discard_q && !start && !skip_load;
   assign frame_hit = rx_ferr && !rx_discard_q && (ld_state_q != L_DONE);
   assign word_asm  = {rx_shift_q, buf_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_state_q <= L_LEN;
         b_q        <= '0;
         buf_q      <= '0;
         n_words_q  <= '0;
         wcnt_q     <= '0;
         tmo_q      <= '0;
         over_cnt_q <= '0;
         status_q   <= '0;
         data_q     <= '0;
         addr_q     <= BASE_ADDR;
         write_q    <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         ld_state_q <= ld_state_n;
         b_q        <= b_n;
         buf_q      <= buf_n;
         n_words_q  <= n_words_n;
         wcnt_q     <= wcnt_n;
         tmo_q      <= tmo_n;
         over_cnt_q <= over_cnt_n;
         status_q   <= status_n;
         data_q     <= data_n;
         addr_q     <= addr_n;
         write_q    <= write_n;
         over_q     <= over_n;
      end
   end

   always_comb begin
      ld_state_n = ld_state_q;
      b_n        = b_q;
      buf_n      = buf_q;
      n_words_n  = n_words_q;
      wcnt_n     = wcnt_q;
      tmo_n      = '0;
      over_cnt_n = over_cnt_q;
      status_n   = status_q;
      data_n     = data_q;
      addr_n     = addr_q;
      write_n    = 1'b0;
      over_n     = over_q;
      case (ld_state_q)
         L_LEN, L_DATA: begin
            if (byte_ok) begin
               if (b_q != 2'd3) begin
                  b_n   = b_q + 2'd1;
                  buf_n = {rx_shift_q, buf_q[23:8]};
               end else begin
                  b_n = 2'd0;
                  if (ld_state_q == L_LEN) begin
                     if (word_asm == 32'd0) begin
                        ld_state_n = L_DONE;
                        over_cnt_n = 2'd0;
                     end else begin
                        ld_state_n = L_DATA;
                        wcnt_n     = '0;
                        if (word_asm > MAX_W) begin
                           n_words_n   = MAX_W;
                           status_n[2] = 1'b1;
                        end else begin
                           n_words_n = word_asm;
                        end
                     end
                  end else begin
                     data_n  = word_asm;
                     addr_n  = BASE_ADDR + {wcnt_q[29:0], 2'b00};
                     write_n = 1'b1;
                     wcnt_n  = wcnt_q + 32'd1;
                     // Two-clk delay lets the final write land on memclk before the CPU leaves reset.
                     if (wcnt_q + 32'd1 >= n_words_q) begin
                        ld_state_n = L_DONE;
                        over_cnt_n = 2'd2;
                     end
                  end
               end
            end else if (ld_state_q == L_DATA || b_q != 2'd0) begin
               if (tmo_q == TMO_LAST) begin
                  status_n[1] = 1'b1;
                  b_n         = 2'd0;
                  wcnt_n      = '0;
                  ld_state_n  = L_LEN;
               end else begin
                  tmo_n = tmo_q + TMO_W'(1);
               end
            end
         end
         default: begin
            if (over_cnt_q != 2'd0) over_cnt_n = over_cnt_q - 2'd1;
            if (over_cnt_q <= 2'd1) over_n = 1'b1;
         end
      endcase

      if (frame_hit) status_n[0] = 1'b1;

      if (skip_load) begin
         ld_state_n = L_DONE;
         over_cnt_n = 2'd0;
         over_n     = 1'b1;
      end

      if (start) begin
         ld_state_n = L_LEN;
         b_n        = 2'd0;
         wcnt_n     = '0;
         tmo_n      = '0;
         over_cnt_n = 2'd0;
         status_n   = '0;
         addr_n     = BASE_ADDR;
         over_n     = 1'b0;
      end
   end

   assign uart.UartData    = data_q;
   assign uart.UartAddress = addr_q;
   assign uart.UartWrite   = write_q;
   assign uart.UartOver    = over_q;
   assign words_loaded     = (|wcnt_q[31:16]) ? 16'hFFFF : wcnt_q[15:0];
   assign status           = status_q;

endmodule
